// File: rtl/reg_file_bank.sv
// reg_file_bank: R0-R14 clocked storage with two operand read ports and a
// debug read port. Address 15 reads the live PC+8 input. Writes come from
// one general port and one dedicated link (R14) port. Reads are combinational
// and show pre-edge contents; there is no write-to-read bypass.
module reg_file_bank #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [3:0]   a1,
  input  logic [3:0]   a2,
  input  logic [3:0]   a3,
  input  logic         we3,
  input  logic [W-1:0] wd3,
  input  logic         we_lr,
  input  logic [W-1:0] wd_lr,
  input  logic [W-1:0] r15,
  input  logic [3:0]   dbg_sel,
  output logic [W-1:0] rd1,
  output logic [W-1:0] rd2,
  output logic [W-1:0] dbg_out
);

  localparam int NREG = 15;

  logic [NREG-1:0][W-1:0] regs;
  logic [15:0][W-1:0]     view;
  logic                   gp_hits_lr;

  // The general port owns R14 when both ports target it on the same edge
  assign gp_hits_lr = we3 && (a3 == 4'd14);

  // Storage update; a3=15 matches no slot, so PC writes fall through silently
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      regs <= '0;
    end else begin
      if (we_lr && !gp_hits_lr)
        regs[NREG-1] <= wd_lr;
      for (int i = 0; i < NREG; i++) begin
        if (we3 && (a3 == 4'(i)))
          regs[i] <= wd3;
      end
    end
  end

  // 16-entry read view: slot 15 is the PC+8 input, never stored
  assign view = {r15, regs};

  // Combinational read ports
  assign rd1     = view[a1];
  assign rd2     = view[a2];
  assign dbg_out = view[dbg_sel];

endmodule
